// File: rtl/mem_access_unit.sv
// Multicycle load/store sequencer: word-aligned memory read, load lane
// shifting, read-merge-write for sub-word stores, and misalignment flagging.
module mem_access_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [1:0]  LScontrol,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic [31:0] MemDataReg_out
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  state_t      state;
  state_t      next_state;
  logic [31:0] addr_q;
  logic [31:0] store_data_q;
  logic [31:0] rdata_q;
  logic [1:0]  lsc_q;
  logic        store_q;
  logic [3:0]  cnt;
  logic        illegal;
  logic        read_last;
  logic [31:0] merged;

  // Alignment rules: size code 00 is never legal, words need addr[1:0]=0,
  // halfwords need addr[0]=0, bytes are always aligned.
  assign illegal   = (LScontrol == 2'b00) ||
                     ((LScontrol == 2'b01) && (addr[1:0] != 2'b00)) ||
                     ((LScontrol == 2'b10) && addr[0]);
  assign read_last = (cnt == 4'd0);

  // State register; reset returns to IDLE immediately so a pending write is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state selection; start is only honoured from IDLE
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (illegal)                               next_state = ERR;
          else if (is_store && LScontrol == 2'b01)   next_state = WRITE;
          else                                       next_state = READ;
        end
      end
      READ:    if (read_last) next_state = store_q ? WRITE : DONE;
      WRITE:   next_state = DONE;
      DONE:    next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Decoded outputs; the memory address is only presented while an access is active
  always_comb begin
    busy       = (state != IDLE);
    done       = (state == DONE) || (state == ERR);
    misaligned = (state == ERR);
    mem_we     = (state == WRITE);
    mem_addr   = (state != IDLE) ? {addr_q[31:2], 2'b00} : 32'd0;
    mem_wdata  = (state == WRITE) ? merged : 32'd0;
  end

  // Write data: whole word for word stores, otherwise the read word with one lane replaced
  always_comb begin
    merged = rdata_q;
    case (lsc_q)
      2'b10:   merged[{addr_q[1], 4'b0000} +: 16] = store_data_q[15:0];
      2'b11:   merged[{addr_q[1:0], 3'b000} +: 8] = store_data_q[7:0];
      default: merged = store_data_q;
    endcase
  end

  // Request latch, latency counter, read capture and load result register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q         <= 32'd0;
      store_data_q   <= 32'd0;
      lsc_q          <= 2'b00;
      store_q        <= 1'b0;
      cnt            <= 4'd0;
      rdata_q        <= 32'd0;
      MemDataReg_out <= 32'd0;
    end else begin
      if (state == IDLE && start) begin
        addr_q       <= addr;
        store_data_q <= store_data;
        lsc_q        <= LScontrol;
        store_q      <= is_store;
        cnt          <= LAT;
      end else if (state == READ) begin
        if (read_last) begin
          rdata_q <= mem_rdata;
          if (!store_q) MemDataReg_out <= mem_rdata >> {addr_q[1:0], 3'b000};
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

endmodule
